// File: rtl/input_debouncer_pkg.sv
// Shared helpers for the input debouncer: counter sizing used by every bit filter.
package input_debouncer_pkg;

    // Width needed to hold values 0..stable_count without wrapping.
    function automatic int unsigned cnt_width(input int unsigned stable_count);
        return (stable_count < 1) ? 1 : $clog2(stable_count + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debounce filter: the level follows the input only after stable_count
// consecutive enabled samples disagree with it, with registered edge pulses.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int stable_count = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_level,
    input  logic sample_en,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic fire
);

    localparam int unsigned   CW   = cnt_width(stable_count);
    localparam logic [CW-1:0] TERM = CW'(stable_count - 1);

    logic [CW-1:0] cnt;
    logic          level;

    // Next-state pulse term, exported so the top can register an aligned OR.
    assign fire = sample_en && (in != level) && (cnt == TERM);
    assign out  = level;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= reset_level;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample_en) begin
                if (in == level) begin
                    cnt <= '0;
                end else if (fire) begin
                    level <= in;
                    cnt   <= '0;
                    rise  <= in;
                    fall  <= ~in;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Multi-bit input debouncer: one independent filter per bit plus a registered
// summary pulse that coincides with any rise or fall.
module input_debouncer #(
    parameter int width        = 1,
    parameter int stable_count = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_level,
    input  logic             sample_en,
    input  logic [width-1:0] in,
    output logic [width-1:0] out,
    output logic [width-1:0] rise,
    output logic [width-1:0] fall,
    output logic             changed
);

    logic [width-1:0] fire;

    for (genvar g = 0; g < width; g++) begin : g_bit
        debounce_bit #(
            .stable_count(stable_count)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .reset_level(reset_level),
            .sample_en  (sample_en),
            .in         (in[g]),
            .out        (out[g]),
            .rise       (rise[g]),
            .fall       (fall[g]),
            .fire       (fire[g])
        );
    end

    // Registered from the same next-state terms, so it lands on the pulse cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            changed <= 1'b0;
        end else begin
            changed <= |fire;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus random traffic,
// checked against a sliding-window model of the debounce rule.
module tb_input_debouncer;

    localparam int W = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         reset_level;
    logic         sample_en;
    logic [W-1:0] tb_in;
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per bit, the enabled samples seen since the last level change.
    bit           hist [W][$];
    logic [W-1:0] m_out;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         m_changed;

    input_debouncer #(
        .width       (W),
        .stable_count(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reset_level(reset_level),
        .sample_en  (sample_en),
        .in         (tb_in),
        .out        (out),
        .rise       (rise),
        .fall       (fall),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The level flips once the last N enabled samples all disagree with it.
    task automatic model_edge(input logic [W-1:0] i, input logic en, input logic rst,
                              input logic rl);
        m_rise = '0;
        m_fall = '0;
        if (rst) begin
            m_out = {W{rl}};
            for (int b = 0; b < W; b++) hist[b].delete();
        end else if (en) begin
            for (int b = 0; b < W; b++) begin
                bit all_diff;
                hist[b].push_back(i[b]);
                if (hist[b].size() > N) void'(hist[b].pop_front());
                all_diff = (hist[b].size() == N);
                foreach (hist[b][k]) if (hist[b][k] == m_out[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_out[b] = i[b];
                    if (i[b]) m_rise[b] = 1'b1;
                    else      m_fall[b] = 1'b1;
                    hist[b].delete();
                end
            end
        end
        m_changed = |{m_rise, m_fall};
    endtask

    task automatic step(input string tag, input logic [W-1:0] i, input logic en,
                        input logic rst, input logic rl);
        tb_in       = i;
        sample_en   = en;
        reset       = rst;
        reset_level = rl;
        @(posedge clk);
        model_edge(i, en, rst, rl);
        #1;
        chk({tag, ".out"},     out,  m_out);
        chk({tag, ".rise"},    rise, m_rise);
        chk({tag, ".fall"},    fall, m_fall);
        chk({tag, ".changed"}, {3'b000, changed}, {3'b000, m_changed});
    endtask

    task automatic do_reset(input logic rl, input logic [W-1:0] i);
        step("rst", i, 1'b1, 1'b1, rl);
        step("rst", i, 1'b1, 1'b1, rl);
    endtask

    initial begin
        tb_in       = 4'hF;
        sample_en   = 1'b1;
        reset       = 1'b1;
        reset_level = 1'b1;
        m_out       = '0;
        m_rise      = '0;
        m_fall      = '0;
        m_changed   = 1'b0;

        // Reset values for both reset levels.
        do_reset(1'b0, 4'h0);
        chk("t1_out_lvl0", out, 4'h0);
        do_reset(1'b1, 4'hF);
        chk("t1_out_lvl1", out, 4'hF);
        chk("t1_pulses", rise | fall, 4'h0);

        // Clean transition on bit 0: four samples to flip, one-cycle fall.
        for (int k = 0; k < 3; k++) step("t2", 4'hE, 1'b1, 1'b0, 1'b0);
        chk("t2_hold", out, 4'hF);
        step("t2", 4'hE, 1'b1, 1'b0, 1'b0);
        chk("t2_out", out, 4'hE);
        chk("t2_fall", fall, 4'h1);
        chk("t2_changed", {3'b000, changed}, 4'h1);
        step("t2", 4'hE, 1'b1, 1'b0, 1'b0);
        chk("t2_fall_end", fall, 4'h0);

        // Glitch rejection on bit 1.
        do_reset(1'b1, 4'hF);
        for (int k = 0; k < 3; k++) step("t3", 4'hD, 1'b1, 1'b0, 1'b0);
        step("t3", 4'hF, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step("t3", 4'hD, 1'b1, 1'b0, 1'b0);
        chk("t3_no_fall", fall, 4'h0);
        step("t3", 4'hD, 1'b1, 1'b0, 1'b0);
        chk("t3_fall", fall, 4'h2);

        // Prescaled sampling on bit 2.
        do_reset(1'b1, 4'hF);
        for (int k = 0; k < 6; k++) step("t4", 4'hB, (k % 2) == 0, 1'b0, 1'b0);
        chk("t4_hold", out, 4'hF);
        step("t4", 4'hB, 1'b1, 1'b0, 1'b0);
        chk("t4_fall", fall, 4'h4);
        step("t4", 4'hB, 1'b0, 1'b0, 1'b0);
        chk("t4_fall_end", fall, 4'h0);
        chk("t4_out", out, 4'hB);

        // All bits at once, then a lone rise on bit 3.
        do_reset(1'b1, 4'hF);
        for (int k = 0; k < 4; k++) step("t5", 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_fall", fall, 4'hF);
        chk("t5_changed", {3'b000, changed}, 4'h1);
        for (int k = 0; k < 4; k++) step("t5", 4'h8, 1'b1, 1'b0, 1'b0);
        chk("t5_rise", rise, 4'h8);

        // Reset mid-count discards progress.
        do_reset(1'b1, 4'hF);
        for (int k = 0; k < 3; k++) step("t6", 4'hE, 1'b1, 1'b0, 1'b0);
        step("t6", 4'hE, 1'b1, 1'b1, 1'b1);
        chk("t6_out", out, 4'hF);
        chk("t6_fall", fall, 4'h0);
        for (int k = 0; k < 3; k++) step("t6", 4'hE, 1'b1, 1'b0, 1'b0);
        chk("t6_no_fall", fall, 4'h0);
        step("t6", 4'hE, 1'b1, 1'b0, 1'b0);
        chk("t6_fall_late", fall, 4'h1);

        // Random traffic: sparse toggles, random qualifier, occasional reset.
        begin
            logic [W-1:0] cur;
            cur = tb_in;
            for (int k = 0; k < 600; k++) begin
                logic [W-1:0] flip;
                for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 5) == 0);
                cur = cur ^ flip;
                step("rnd", cur, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Consumes the output bus of a 2-stage synchronizer, which is already on the `clk` domain, typically driven from DE0-Nano buttons and DIP switches.
- Each bit is filtered independently. A bit's output changes only after its input has held the new value for `stable_count` consecutive enabled samples.
- Registered single-cycle rise and fall pulses are produced for downstream control logic.
- Sits directly downstream of the synchronizer and upstream of any edge-triggered consumers.

Parameters:
- `width`, 1, number of independent input bits.
- `stable_count`, 50000, consecutive enabled samples of a changed value required before the output follows (1 ms at 50 MHz with `sample_en` tied high). Must be >= 1.

Ports:
- `clk`  input  1  sole clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `reset_level`  input  1  value loaded into every `out` bit on reset.
- `sample_en`  input  1  sample qualifier / prescaler tick; tie to 1 for every-cycle sampling.
- `in`  input  width  synchronized raw inputs.
- `out`  output  width  debounced levels.
- `rise`  output  width  one-cycle pulse per bit on `out` 0->1.
- `fall`  output  width  one-cycle pulse per bit on `out` 1->0.
- `changed`  output  1  one-cycle pulse, the OR of all `rise` and `fall` bits. Registered, so it coincides exactly with the pulses.

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is synchronous and active-high.
- Reset (sampled on the `clk` rising edge, overrides everything):
  - `out` = {width{reset_level}}.
  - All counters = 0.
  - `rise`, `fall`, `changed` = 0.
- Per-bit state: `level` (drives `out[i]`) and counter `cnt`, `$clog2(stable_count+1)` bits wide, unsigned, never wraps.
- Each rising edge, not in reset, per bit i:
  - `rise[i]` and `fall[i]` default to 0, so every pulse lasts exactly one cycle.
  - If `sample_en` = 0: `level` and `cnt` hold. Pulses still clear to 0.
  - Else if `in[i]` == `level`: `cnt` <= 0 (a glitch fully restarts the count).
  - Else if `cnt` == `stable_count-1`:
    - `level` <= `in[i]` and `cnt` <= 0.
    - Pulse `rise[i]` if `in[i]` = 1, otherwise pulse `fall[i]`.
  - Else: `cnt` <= `cnt`+1.
- Latency: suppose `in[i]` differs from `out[i]` at N = `stable_count` consecutive enabled edges k1..kN. Then `out[i]` and its pulse update at edge kN and are visible the cycle after it.
  - With `sample_en` = 1 this is N clocks after the first differing sample.
  - `stable_count` = 1 gives a plain 1-cycle registered follower with edge pulses.
- `rise[i]` and `fall[i]` are never both 1. A bit can pulse at most once per `stable_count` enabled samples.
- Bits are fully independent. Several bits may pulse in the same cycle; `changed` is 1 once for that cycle.
- Reset mid-count discards partial counts. After release a full `stable_count` run is required again, measured against `reset_level`.
- `reset_level` is sampled only while `reset` = 1.
- `in` X after reset: not supported. The upstream synchronizer is reset as well.

Decomposition:
- No shared package is needed.
- Counter width is a localparam derived via `$clog2` inside the bit module.
- One sub-module is natural: `debounce_bit`, the single-bit filter.
  - Ports: `clk`, `reset`, `reset_level`, `sample_en`, `in`, `out`, `rise`, `fall`; parameter `stable_count`.
  - Instantiated `width` times via a generate loop in `input_debouncer`.
- `changed` is registered in the top level as the OR of the next-state pulse terms.

Test Plan:
1. Reset values: `width`=4, `stable_count`=4, `reset_level`=1, `in`=4'hF, hold `reset` 2 cycles -> `out`=4'hF, `rise`=`fall`=0, `changed`=0. Repeat with `reset_level`=0 -> `out`=4'h0.
2. Clean transition: `sample_en`=1, drive `in[0]`=0 from edge 0 onward -> `out[0]` still 1 after edges 0-2; `out[0]`=0 and `fall[0]`=1 after edge 3; `fall[0]`=0 after edge 4. `changed` pulses in the same cycle as `fall[0]`.
3. Glitch rejection: `in[1]`=0 for 3 cycles, then 1 for 1 cycle, then 0 for 4 cycles -> no pulse during the first 3+1 cycles. `fall[1]` fires only after the 4th cycle of the second run (8th edge overall).
4. Prescaling: `sample_en` high every other cycle, `in[2]` 1->0 held -> `out[2]` changes after the 4th enabled edge (~8 clocks). `fall[2]` is exactly one clock wide, even though the next cycle has `sample_en`=0.
5. Independent and simultaneous bits: `in` 4'hF -> 4'h0 at once -> all four `fall` bits pulse together on the same cycle, `changed`=1 once. Then `in[3]`=1 only -> `rise`=4'h8 only.
6. Reset mid-count: after 3 mismatched samples on `in[0]`, assert `reset` 1 cycle with `reset_level`=1 -> `out`=4'hF, no pulse. After release, a fresh 4 samples are needed before `fall[0]` fires.
